// File: rtl/shift_rows_pkg.sv
// ============================================================================
// Module : shift_rows_pkg
// Brief  : Shared limits and row-offset rule for the ShiftRows pipeline stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package shift_rows_pkg;

  localparam int NB_MIN = 4;
  localparam int NB_MAX = 8;

  // Rijndael row offsets: wider states push the upper rows one column further.
  function automatic int row_offset(input int nb, input int r);
    int off;
    off = r;
    if ((nb == 7) && (r == 3)) off = 4;
    if ((nb == 8) && (r >= 2)) off = r + 1;
    return off;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_rows_perm.sv
// ============================================================================
// Module : shift_rows_perm
// Brief  : Combinational ShiftRows / InvShiftRows byte permutation.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module shift_rows_perm
  import shift_rows_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic [NB*32-1:0] i_block,
  input  logic             i_inv,
  output logic [NB*32-1:0] o_block
);

  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int c_off = row_offset(NB, r);
      localparam int c_fwd = (c + c_off) % NB;
      localparam int c_inv = (c - c_off + NB) % NB;

      assign o_block[NB*32-1-32*c-8*r -: 8] = i_inv
          ? i_block[NB*32-1-32*c_inv-8*r -: 8]
          : i_block[NB*32-1-32*c_fwd-8*r -: 8];
    end
  end

endmodule

`default_nettype wire

// File: rtl/shift_rows_pipe.sv
// ============================================================================
// Module : shift_rows_pipe
// Brief  : ShiftRows stage with a 2-entry output FIFO and valid/ready flow.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module shift_rows_pipe
  import shift_rows_pkg::*;
#(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [NB*32-1:0] i_block,
  input  logic             i_inv,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [NB*32-1:0] o_block,
  output logic [TAG_W-1:0] o_tag
);

  localparam int c_bw = NB * 32;

  if ((NB < NB_MIN) || (NB > NB_MAX)) begin : g_nb_check
    $error("shift_rows_pipe: NB=%0d outside legal range", NB);
  end

  logic [c_bw-1:0]             w_perm;
  logic                        w_push;
  logic                        w_pop;
  logic [1:0][c_bw-1:0]        r_mem_block;
  logic [1:0][TAG_W-1:0]       r_mem_tag;
  logic                        r_wr_ptr;
  logic                        r_rd_ptr;
  logic [1:0]                  r_count;

  shift_rows_perm #(
    .NB (NB)
  ) u_perm (
    .i_block (i_block),
    .i_inv   (i_inv),
    .o_block (w_perm)
  );

  // Status flags come only from the registered count, never from i_ready.
  assign o_ready = (r_count != 2'd2);
  assign o_valid = (r_count != 2'd0);
  assign w_push  = i_valid & o_ready;
  assign w_pop   = o_valid & i_ready;
  assign o_block = r_mem_block[r_rd_ptr];
  assign o_tag   = r_mem_tag[r_rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem_block <= '0;
      r_mem_tag   <= '0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem_block[r_wr_ptr] <= w_perm;
        r_mem_tag[r_wr_ptr]   <= i_tag;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_rows_pipe.sv
// ============================================================================
// Module : tb_shift_rows_pipe
// Brief  : Self-checking bench for shift_rows_pipe (NB=4 and NB=8 instances).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_shift_rows_pipe;

  logic         clk;
  logic         rst_n;

  logic         in_valid, in_inv, in_ready, out_valid, out_ready;
  logic [127:0] in_block, out_block;
  logic [3:0]   in_tag, out_tag;

  logic         d8_in_valid, d8_in_inv, d8_in_ready, d8_out_valid, d8_out_ready;
  logic [255:0] d8_in_block, d8_out_block;
  logic [3:0]   d8_in_tag, d8_out_tag;

  int checks = 0;
  int errors = 0;

  shift_rows_pipe #(.NB(4), .TAG_W(4)) dut (
    .i_clk   (clk),       .i_rst_n (rst_n),
    .i_valid (in_valid),  .o_ready (out_ready),
    .i_block (in_block),  .i_inv   (in_inv),
    .i_tag   (in_tag),    .o_valid (out_valid),
    .i_ready (in_ready),  .o_block (out_block),
    .o_tag   (out_tag)
  );

  shift_rows_pipe #(.NB(8), .TAG_W(4)) dut8 (
    .i_clk   (clk),         .i_rst_n (rst_n),
    .i_valid (d8_in_valid), .o_ready (d8_out_ready),
    .i_block (d8_in_block), .i_inv   (d8_in_inv),
    .i_tag   (d8_in_tag),   .o_valid (d8_out_valid),
    .i_ready (d8_in_ready), .o_block (d8_out_block),
    .o_tag   (d8_out_tag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: state as a byte matrix, each row rotated by its offset.
  function automatic logic [255:0] ref_shift(input int nb, input logic [255:0] blk, input bit inv);
    logic [7:0]   s [8][4];
    logic [255:0] res;
    int           off [4];
    int           src;
    if (nb <= 6)      off = '{0, 1, 2, 3};
    else if (nb == 7) off = '{0, 1, 2, 4};
    else              off = '{0, 1, 3, 4};
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++)
        s[c][r] = blk[nb*32-1-32*c-8*r -: 8];
    res = '0;
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++) begin
        src = inv ? (c - off[r] + nb) % nb : (c + off[r]) % nb;
        res[nb*32-1-32*c-8*r -: 8] = s[src][r];
      end
    return res;
  endfunction

  function automatic logic [127:0] ref4(input logic [127:0] blk, input bit inv);
    logic [255:0] t;
    t = ref_shift(4, {128'b0, blk}, inv);
    return t[127:0];
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_ready !== 1'b1 || out_block !== '0 || out_tag !== '0) begin
      errors++;
      $display("FAIL reset_during: valid=%b ready=%b block=%h tag=%h, required 0 1 0 0",
               out_valid, out_ready, out_block, out_tag);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_ready !== 1'b1 || d8_out_valid !== 1'b0 || d8_out_block !== '0) begin
      errors++;
      $display("FAIL reset_after: valid=%b ready=%b d8_valid=%b, required 0 1 0",
               out_valid, out_ready, d8_out_valid);
    end
  endtask

  task automatic test_fips(input bit inv, input logic [127:0] blk, input logic [127:0] exp);
    in_valid = 1'b1; in_inv = inv; in_block = blk; in_tag = 4'h5; in_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_block !== exp || out_tag !== 4'h5) begin
      errors++;
      $display("FAIL fips_inv%0b: valid=%b block=%h tag=%h, required 1 %h 5",
               inv, out_valid, out_block, out_tag, exp);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL fips_drain: valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_nb8;
    logic [255:0] orig, fwd;
    for (int i = 0; i < 32; i++) orig[255-8*i -: 8] = 8'(i);
    fwd = ref_shift(8, orig, 1'b0);
    d8_in_ready = 1'b1; d8_in_valid = 1'b1; d8_in_inv = 1'b0; d8_in_block = orig; d8_in_tag = 4'ha;
    @(negedge clk);
    checks++;
    if (d8_out_valid !== 1'b1 || d8_out_block[255:224] !== 32'h00050e13 || d8_out_block !== fwd) begin
      errors++;
      $display("FAIL nb8_fwd: valid=%b block=%h, required 1 %h (col0 00050e13)",
               d8_out_valid, d8_out_block, fwd);
    end
    d8_in_inv = 1'b1; d8_in_block = d8_out_block; d8_in_tag = 4'hb;
    @(negedge clk);
    d8_in_valid = 1'b0;
    checks++;
    if (d8_out_valid !== 1'b1 || d8_out_block !== orig || d8_out_tag !== 4'hb) begin
      errors++;
      $display("FAIL nb8_inv: valid=%b block=%h tag=%h, required 1 %h b",
               d8_out_valid, d8_out_block, d8_out_tag, orig);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [127:0] prev_blk;
    logic [3:0]   prev_tag;
    bit           prev_inv;
    in_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      prev_blk = {$urandom, $urandom, $urandom, $urandom};
      prev_inv = 1'($urandom_range(0, 1));
      prev_tag = 4'(i + 3);
      in_valid = 1'b1; in_block = prev_blk; in_inv = prev_inv; in_tag = prev_tag;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_ready !== 1'b1 || out_block !== ref4(prev_blk, prev_inv) || out_tag !== prev_tag) begin
        errors++;
        $display("FAIL b2b_%0d: valid=%b ready=%b block=%h tag=%h, required 1 1 %h %h",
                 i, out_valid, out_ready, out_block, out_tag, ref4(prev_blk, prev_inv), prev_tag);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    in_ready = 1'b0; in_inv = 1'b0; in_block = 128'h0123456789abcdef0011223344556677;
    in_valid = 1'b1; in_tag = 4'd1;
    @(negedge clk);
    checks++;
    if (out_ready !== 1'b1 || out_valid !== 1'b1 || out_tag !== 4'd1) begin
      errors++;
      $display("FAIL bp_one: ready=%b valid=%b tag=%h, required 1 1 1", out_ready, out_valid, out_tag);
    end
    in_tag = 4'd2;
    @(negedge clk);
    in_tag = 4'd3;
    checks++;
    if (out_ready !== 1'b0 || out_tag !== 4'd1) begin
      errors++;
      $display("FAIL bp_full: ready=%b tag=%h, required 0 1", out_ready, out_tag);
    end
    @(negedge clk);
    checks++;
    if (out_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 4'd1 || out_block !== ref4(in_block, 1'b0)) begin
      errors++;
      $display("FAIL bp_hold: ready=%b valid=%b tag=%h, required 0 1 1", out_ready, out_valid, out_tag);
    end
    in_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_ready !== 1'b1 || out_tag !== 4'd2) begin
      errors++;
      $display("FAIL bp_rel1: ready=%b tag=%h, required 1 2", out_ready, out_tag);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 4'd3) begin
      errors++;
      $display("FAIL bp_rel2: valid=%b tag=%h, required 1 3", out_valid, out_tag);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty: valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_stream;
    logic [127:0] q_blk [$];
    logic [3:0]   q_tag [$];
    int           acc = 0;
    int           cyc = 0;
    bit           exp_v, exp_r, do_acc, do_con;
    in_valid = 1'b0; in_ready = 1'b0;
    while ((acc < 100 || q_blk.size() != 0) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      exp_v = (q_blk.size() != 0);
      exp_r = (q_blk.size() != 2);
      checks++;
      if (out_valid !== exp_v || out_ready !== exp_r) begin
        errors++;
        $display("FAIL stream_flags@%0d: valid=%b ready=%b, required %b %b", cyc, out_valid, out_ready, exp_v, exp_r);
      end
      if (exp_v) begin
        checks++;
        if (out_block !== q_blk[0] || out_tag !== q_tag[0]) begin
          errors++;
          $display("FAIL stream_data@%0d: block=%h tag=%h, required %h %h", cyc, out_block, out_tag, q_blk[0], q_tag[0]);
        end
      end
      in_valid = (acc < 100) && ($urandom_range(0, 3) != 0);
      in_ready = ($urandom_range(0, 3) != 0);
      in_block = {$urandom, $urandom, $urandom, $urandom};
      in_inv   = 1'($urandom_range(0, 1));
      in_tag   = 4'($urandom);
      do_acc = in_valid && (q_blk.size() != 2);
      do_con = in_ready && (q_blk.size() != 0);
      if (do_con) begin
        void'(q_blk.pop_front());
        void'(q_tag.pop_front());
      end
      if (do_acc) begin
        q_blk.push_back(ref4(in_block, in_inv));
        q_tag.push_back(in_tag);
        acc++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (acc < 100 || q_blk.size() != 0) begin
      errors++;
      $display("FAIL stream_timeout: accepted=%0d pending=%0d, required 100 0", acc, q_blk.size());
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midstream;
    logic [127:0] blk;
    in_ready = 1'b0; in_valid = 1'b1; in_inv = 1'b0; in_tag = 4'h7;
    in_block = {$urandom, $urandom, $urandom, $urandom};
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_full: ready=%b valid=%b, required 0 1", out_ready, out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_ready !== 1'b1 || out_block !== '0 || out_tag !== '0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b ready=%b block=%h tag=%h, required 0 1 0 0",
               out_valid, out_ready, out_block, out_tag);
    end
    @(negedge clk);
    rst_n = 1'b1; in_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_stale_%0d: valid=%b, required 0", i, out_valid);
      end
    end
    blk = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1; in_block = blk; in_inv = 1'b1; in_tag = 4'hc;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_block !== ref4(blk, 1'b1) || out_tag !== 4'hc) begin
      errors++;
      $display("FAIL mid_new: valid=%b block=%h tag=%h, required 1 %h c",
               out_valid, out_block, out_tag, ref4(blk, 1'b1));
    end
    @(negedge clk);
  endtask

  initial begin
    in_valid = 1'b0; in_inv = 1'b0; in_ready = 1'b0; in_block = '0; in_tag = '0;
    d8_in_valid = 1'b0; d8_in_inv = 1'b0; d8_in_ready = 1'b0; d8_in_block = '0; d8_in_tag = '0;
    test_reset();
    @(negedge clk);
    test_fips(1'b0, 128'hd42711aee0bf98f1b8b45de51e415230, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
    test_fips(1'b1, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 128'hd42711aee0bf98f1b8b45de51e415230);
    test_nb8();
    test_back_to_back();
    test_backpressure();
    test_stream();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
